// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared state encoding and key/timeout constants for the alarm clock controller
package aclk_pkg;

   localparam logic [3:0] NOKEY        = 4'hA;
   localparam int         TIMEOUT_SECS = 10;
   localparam int         CNT_W        = 4;

   typedef enum logic [2:0] {
      SHOW_TIME        = 3'd0,
      KEY_STORED       = 3'd1,
      KEY_WAIT         = 3'd2,
      KEY_ENTRY        = 3'd3,
      SHOW_ALARM       = 3'd4,
      SET_ALARM_TIME   = 3'd5,
      SET_CURRENT_TIME = 3'd6
   } state_e;

   // Codes above 9 (NOKEY and the unused B-F) all count as "no key".
   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// rtl/aclk_timeout_cnt.sv - key-entry inactivity timer counting one_second pulses
module aclk_timeout_cnt
   import aclk_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic one_second,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_SECS - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Holds at LAST so a late pulse still reports expiry instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && one_second && (count_q != LAST)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Not gated by clear: clear is derived from the next state, which depends on expired.
   assign expired = enable & one_second & (count_q == LAST);

endmodule

// File: rtl/aclk_controller.sv
// rtl/aclk_controller.sv - Moore FSM sequencing keypad entry, alarm view and time/alarm loads
module aclk_controller
   import aclk_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       show_a,
   output logic       show_new_time,
   output logic       shift,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       reset_count
);

   state_e state_q, state_d;
   logic   timing;
   logic   tmo_clear;
   logic   expired;

   assign timing    = (state_q == KEY_WAIT) || (state_q == KEY_ENTRY);
   assign tmo_clear = !timing || (state_d == KEY_STORED);

   aclk_timeout_cnt u_timeout (
      .clock      (clock),
      .reset      (reset),
      .clear      (tmo_clear),
      .enable     (timing),
      .one_second (one_second),
      .expired    (expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SHOW_TIME;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SHOW_TIME: begin
            if (alarm_button)       state_d = SHOW_ALARM;
            else if (is_digit(key)) state_d = KEY_STORED;
         end
         KEY_STORED: state_d = KEY_WAIT;
         KEY_WAIT: begin
            // A held key must be released before another digit is accepted.
            if (!is_digit(key)) state_d = KEY_ENTRY;
            else if (expired)   state_d = SHOW_TIME;
         end
         KEY_ENTRY: begin
            if (alarm_button)       state_d = SET_ALARM_TIME;
            else if (time_button)   state_d = SET_CURRENT_TIME;
            else if (is_digit(key)) state_d = KEY_STORED;
            else if (expired)       state_d = SHOW_TIME;
         end
         SHOW_ALARM: begin
            if (!alarm_button) state_d = SHOW_TIME;
         end
         SET_ALARM_TIME:   state_d = SHOW_TIME;
         SET_CURRENT_TIME: state_d = SHOW_TIME;
         default:          state_d = SHOW_TIME;
      endcase
   end

   always_comb begin
      show_a        = 1'b0;
      show_new_time = 1'b0;
      shift         = 1'b0;
      load_new_a    = 1'b0;
      load_new_c    = 1'b0;
      reset_count   = 1'b0;
      case (state_q)
         KEY_STORED: begin
            shift         = 1'b1;
            show_new_time = 1'b1;
         end
         KEY_WAIT:   show_new_time = 1'b1;
         KEY_ENTRY:  show_new_time = 1'b1;
         SHOW_ALARM: show_a        = 1'b1;
         SET_ALARM_TIME: load_new_a = 1'b1;
         SET_CURRENT_TIME: begin
            load_new_c  = 1'b1;
            reset_count = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aclk_controller.sv
// tb/tb_aclk_controller.sv - directed self-checking bench for aclk_controller
module tb_aclk_controller;
   import aclk_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       one_second;
   logic [3:0] key;
   logic       alarm_button;
   logic       time_button;
   logic       show_a, show_new_time, shift, load_new_a, load_new_c, reset_count;

   int total = 0;
   int bad   = 0;
   int shift_cnt = 0;

   // {show_a, show_new_time, shift, load_new_a, load_new_c, reset_count}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_ALARM = 6'b100000;
   localparam logic [5:0] O_STORE = 6'b011000;
   localparam logic [5:0] O_ENTRY = 6'b010000;
   localparam logic [5:0] O_LDA   = 6'b000100;
   localparam logic [5:0] O_LDC   = 6'b000011;

   wire [5:0] outs = {show_a, show_new_time, shift, load_new_a, load_new_c, reset_count};

   aclk_controller dut (
      .clock         (clock),
      .reset         (reset),
      .one_second    (one_second),
      .key           (key),
      .alarm_button  (alarm_button),
      .time_button   (time_button),
      .show_a        (show_a),
      .show_new_time (show_new_time),
      .shift         (shift),
      .load_new_a    (load_new_a),
      .load_new_c    (load_new_c),
      .reset_count   (reset_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (shift) shift_cnt++;
      chk("excl_show", 32'(show_a & show_new_time), 32'd0);
      chk("excl_strobe", 32'(($countones({shift, load_new_a, load_new_c}) > 1) ? 1 : 0), 32'd0);
   endtask

   initial begin
      reset = 1'b1; one_second = 1'b0; key = NOKEY;
      alarm_button = 1'b0; time_button = 1'b0;
      tick();
      // Reset overrides a pending alarm request
      alarm_button = 1'b1;
      tick();
      chk("reset_outs", 32'(outs), 32'(O_IDLE));
      chk("reset_state", 32'(dut.state_q), 32'(SHOW_TIME));
      chk("reset_cnt", 32'(dut.u_timeout.count_q), 32'd0);

      // Alarm view held 5 cycles, first edge after reset release responds
      reset = 1'b0; time_button = 1'b1; key = 4'd3;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("alarm_view", 32'(outs), 32'(O_ALARM));
      end
      alarm_button = 1'b0; time_button = 1'b0; key = NOKEY;
      tick();
      chk("alarm_release", 32'(outs), 32'(O_IDLE));

      // Four digits then time_button
      shift_cnt = 0;
      for (int d = 1; d <= 4; d++) begin
         key = 4'(d);
         tick();
         chk("digit_store", 32'(outs), 32'(O_STORE));
         tick();
         chk("digit_wait", 32'(outs), 32'(O_ENTRY));
         key = NOKEY;
         tick();
         chk("digit_entry", 32'(outs), 32'(O_ENTRY));
      end
      time_button = 1'b1;
      tick();
      chk("set_time", 32'(outs), 32'(O_LDC));
      time_button = 1'b0;
      tick();
      chk("set_time_done", 32'(outs), 32'(O_IDLE));
      chk("four_shifts", 32'(shift_cnt), 32'd4);

      // Reset mid-KEY_WAIT
      key = 4'd8;
      tick();
      tick();
      chk("kw_before_rst", 32'(dut.state_q), 32'(KEY_WAIT));
      reset = 1'b1;
      tick();
      chk("rst_kw_outs", 32'(outs), 32'(O_IDLE));
      chk("rst_kw_state", 32'(dut.state_q), 32'(SHOW_TIME));
      reset = 1'b0; key = NOKEY;
      tick();

      // Held digit 5: one shift, timeout on the 10th second
      shift_cnt = 0;
      key = 4'd5;
      tick();
      chk("held_store", 32'(outs), 32'(O_STORE));
      for (int i = 0; i < 20; i++) tick();
      chk("held_wait", 32'(outs), 32'(O_ENTRY));
      chk("held_one_shift", 32'(shift_cnt), 32'd1);
      for (int p = 1; p <= 10; p++) begin
         one_second = 1'b1;
         tick();
         one_second = 1'b0;
         if (p == 10) begin
            chk("held_timeout", 32'(outs), 32'(O_IDLE));
            key = NOKEY;
         end else begin
            chk("held_pre_tmo", 32'(outs), 32'(O_ENTRY));
            tick();
         end
      end
      tick();
      chk("held_idle", 32'(outs), 32'(O_IDLE));

      // Alarm and time buttons together in KEY_ENTRY
      key = 4'd6;
      tick();
      key = NOKEY;
      tick();
      tick();
      chk("both_entry", 32'(dut.state_q), 32'(KEY_ENTRY));
      alarm_button = 1'b1; time_button = 1'b1;
      tick();
      chk("both_lda", 32'(outs), 32'(O_LDA));
      alarm_button = 1'b0; time_button = 1'b0;
      tick();
      chk("both_done", 32'(outs), 32'(O_IDLE));

      // Digit coincident with the 10th second in KEY_ENTRY
      key = 4'd7;
      tick();
      key = NOKEY;
      tick();
      tick();
      for (int p = 1; p <= 9; p++) begin
         one_second = 1'b1;
         tick();
         one_second = 1'b0;
      end
      chk("cnt_nine", 32'(dut.u_timeout.count_q), 32'd9);
      chk("entry_pre_tmo", 32'(outs), 32'(O_ENTRY));
      key = 4'd7; one_second = 1'b1;
      tick();
      one_second = 1'b0;
      chk("digit_beats_tmo", 32'(outs), 32'(O_STORE));
      chk("cnt_cleared", 32'(dut.u_timeout.count_q), 32'd0);
      // Reset during the shift strobe
      reset = 1'b1; key = NOKEY;
      tick();
      chk("rst_strobe", 32'(outs), 32'(O_IDLE));
      reset = 1'b0;

      // Plain timeout from KEY_ENTRY
      key = 4'd9;
      tick();
      key = NOKEY;
      tick();
      tick();
      for (int p = 1; p <= 10; p++) begin
         one_second = 1'b1;
         tick();
         one_second = 1'b0;
         if (p == 9) chk("entry_nine", 32'(outs), 32'(O_ENTRY));
      end
      chk("entry_timeout", 32'(outs), 32'(O_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aclk_controller.md
ACLK_CONTROLLER -- requirements
Module: aclk_controller

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: one_second  input  1  one-cycle pulse per elapsed second.
REQ-004 SHALL have port: key  input  4  keypad code; 0-9 digit, 4'hA = no key (NOKEY), 4'hB-4'hF treated as NOKEY.
REQ-005 SHALL have port: alarm_button  input  1  level, alarm-view/alarm-set request.
REQ-006 SHALL have port: time_button  input  1  level, set-current-time request.
REQ-007 SHALL have port: show_a  output  1  display selects alarm time.
REQ-008 SHALL have port: show_new_time  output  1  display selects keyed digits.
REQ-009 SHALL have port: shift  output  1  one-cycle strobe; key register shifts in current key.
REQ-010 SHALL have port: load_new_a  output  1  one-cycle strobe; alarm register loads keyed time.
REQ-011 SHALL have port: load_new_c  output  1  one-cycle strobe; time counter loads keyed time.
REQ-012 SHALL have port: reset_count  output  1  one-cycle strobe, coincident with load_new_c; clears seconds prescaler.

Function
REQ-013 SHALL implement a Moore FSM; outputs decoded from the state register only, no combinational input-to-output path.
REQ-014 SHALL have states SHOW_TIME, KEY_STORED, KEY_WAIT, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
REQ-015 SHOW_TIME: alarm_button=1 -> SHOW_ALARM; else valid digit -> KEY_STORED; else stay; all outputs 0.
REQ-016 KEY_STORED: shift=1, show_new_time=1; unconditionally -> KEY_WAIT next cycle (shift exactly one cycle per key press).
REQ-017 KEY_WAIT: show_new_time=1; key=NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay (held key never shifts twice).
REQ-018 KEY_ENTRY: show_new_time=1; priority alarm_button -> SET_ALARM_TIME, then time_button -> SET_CURRENT_TIME, then valid digit -> KEY_STORED, then timeout -> SHOW_TIME, else stay.
REQ-019 SHOW_ALARM: show_a=1; alarm_button=0 -> SHOW_TIME; key and time_button ignored.
REQ-020 SET_ALARM_TIME: load_new_a=1 for one cycle; -> SHOW_TIME.
REQ-021 SET_CURRENT_TIME: load_new_c=1 and reset_count=1 for one cycle; -> SHOW_TIME.
REQ-022 Timeout counter (4 bits) SHALL clear on every entry to KEY_STORED and in all states except KEY_WAIT/KEY_ENTRY; increments on one_second while in KEY_WAIT or KEY_ENTRY.
REQ-023 Timeout SHALL fire on the cycle one_second is high with count=9 (10th pulse); counter saturates, never wraps to 0 while timing.
REQ-024 Simultaneous timeout and button/digit in KEY_ENTRY SHALL resolve to the button/digit per REQ-018; in KEY_WAIT a held key with timeout -> SHOW_TIME.
REQ-025 At most one of show_a, show_new_time SHALL be 1; at most one of shift, load_new_a, load_new_c in any cycle.

Reset
REQ-026 reset=1 at a clock edge SHALL force state SHOW_TIME, timeout count 0, all outputs 0 the following cycle, overriding all inputs, including mid-entry or mid-strobe.
REQ-027 After reset deassertion the FSM SHALL respond to inputs on the first subsequent edge.

Structure
REQ-028 State encoding, NOKEY (4'hA) and TIMEOUT_SECS (10) SHALL live in shared package aclk_pkg.
REQ-029 Timeout counter SHALL be sub-module aclk_timeout_cnt (inputs clear, enable, one_second; output expired).

Verification
REQ-030 Reset mid-KEY_WAIT -> next cycle state SHOW_TIME, all outputs 0.
REQ-031 Key 1,NOKEY,2,NOKEY,3,NOKEY,4,NOKEY then time_button -> exactly 4 shift pulses, then one cycle load_new_c=1 with reset_count=1, return to SHOW_TIME.
REQ-032 Digit 5 held 20 cycles -> single shift pulse; 10 one_second pulses while held -> SHOW_TIME on the 10th.
REQ-033 KEY_ENTRY with alarm_button=1 and time_button=1 same cycle -> load_new_a=1 only, load_new_c stays 0.
REQ-034 alarm_button held 5 cycles in SHOW_TIME -> show_a=1 for those cycles, 0 one cycle after release; no strobes.
REQ-035 KEY_ENTRY with digit 7 coincident with 10th one_second -> KEY_STORED, shift=1, counter cleared.
